// File: rtl/toy_bus_ack_sched.sv
// Registered N-to-1 ToyBusAck scheduler with least-recently-granted age matrix and a one-deep output register.
// Optional starvation watchdog under `TOY_BUS_ACK_SCHED_STARVE_WDOG_EN (adds starve_err port).
module toy_bus_ack_sched #(
  parameter int NUM_IN    = 4,
  parameter int DATA_W    = 256,
  parameter int SB_W      = 32,
  parameter int ID_W      = 4,
  parameter int STARVE_TH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_IN-1:0]          in_vld,
  output logic [NUM_IN-1:0]          in_rdy,
  input  logic [NUM_IN-1:0]          in_opcode,
  input  logic [NUM_IN*DATA_W-1:0]   in_data,
  input  logic [NUM_IN*SB_W-1:0]     in_sideband,
  input  logic [NUM_IN*ID_W-1:0]     in_src_id,
  input  logic [NUM_IN*ID_W-1:0]     in_tgt_id,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic                       out_opcode,
  output logic [DATA_W-1:0]          out_data,
  output logic [SB_W-1:0]            out_sideband,
  output logic [ID_W-1:0]            out_src_id,
  output logic [ID_W-1:0]            out_tgt_id,
  output logic [$clog2(NUM_IN)-1:0]  out_src_idx
`ifdef TOY_BUS_ACK_SCHED_STARVE_WDOG_EN
  ,
  output logic [NUM_IN-1:0]          starve_err
`endif
);

  localparam int IDX_W = $clog2(NUM_IN);
  localparam int NPAIR = NUM_IN * (NUM_IN - 1) / 2;

  if (NUM_IN < 2 || NUM_IN > 8 || STARVE_TH < 1 || STARVE_TH > 255) begin : g_bad_cfg
    $error("toy_bus_ack_sched: parameter out of range");
  end

  // Flat index of the upper-triangle pair (i,j), i<j.
  function automatic int pidx(input int i, input int j);
    return i * NUM_IN - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  logic [NPAIR-1:0]               age_q;
  logic [NUM_IN-1:0][NUM_IN-1:0]  older;
  logic [NUM_IN-1:0]              grant;
  logic [IDX_W-1:0]               win_idx;
  logic                           load;
  logic                           accept;

  always_comb begin
    older = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      for (int j = 0; j < NUM_IN; j++) begin
        if (i < j)      older[i][j] = age_q[pidx(i, j)];
        else if (i > j) older[i][j] = ~age_q[pidx(j, i)];
      end
    end
  end

  always_comb begin
    grant   = '0;
    win_idx = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      grant[i] = in_vld[i];
      for (int j = 0; j < NUM_IN; j++) begin
        if (j != i && in_vld[j] && older[j][i]) grant[i] = 1'b0;
      end
    end
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) win_idx = IDX_W'(i);
    end
  end

  assign load   = ~out_vld | out_rdy;
  assign in_rdy = grant & {NUM_IN{load}};
  assign accept = (|grant) & load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_q        <= '1;
      out_vld      <= 1'b0;
      out_opcode   <= 1'b0;
      out_data     <= '0;
      out_sideband <= '0;
      out_src_id   <= '0;
      out_tgt_id   <= '0;
      out_src_idx  <= '0;
    end else if (load) begin
      out_vld <= accept;
      if (accept) begin
        out_opcode   <= in_opcode[win_idx];
        out_data     <= in_data[win_idx*DATA_W +: DATA_W];
        out_sideband <= in_sideband[win_idx*SB_W +: SB_W];
        out_src_id   <= in_src_id[win_idx*ID_W +: ID_W];
        out_tgt_id   <= in_tgt_id[win_idx*ID_W +: ID_W];
        out_src_idx  <= win_idx;
        // Winner becomes youngest; other pairs keep their relative order.
        for (int i = 0; i < NUM_IN; i++) begin
          for (int j = i + 1; j < NUM_IN; j++) begin
            if (grant[i])      age_q[pidx(i, j)] <= 1'b0;
            else if (grant[j]) age_q[pidx(i, j)] <= 1'b1;
          end
        end
      end
    end
  end

`ifdef TOY_BUS_ACK_SCHED_STARVE_WDOG_EN
  localparam logic [7:0] TH = 8'(STARVE_TH);

  logic [NUM_IN-1:0][7:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt   <= '0;
      starve_err <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        starve_err[i] <= 1'b0;
        if (!in_vld[i] || in_rdy[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != 8'hff) begin
          wait_cnt[i] <= wait_cnt[i] + 8'd1;
          // Fires only on the step into the threshold, never while saturating.
          if (wait_cnt[i] + 8'd1 == TH) starve_err[i] <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_toy_bus_ack_sched.sv
// Bench for toy_bus_ack_sched: LRU-queue reference model plus directed literal checks and randomized traffic.
module tb_toy_bus_ack_sched;
  localparam int N  = 4;
  localparam int DW = 256;
  localparam int SW = 32;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    in_vld, in_rdy, in_opcode;
  logic [N*DW-1:0] in_data;
  logic [N*SW-1:0] in_sideband;
  logic [N*IW-1:0] in_src_id, in_tgt_id;
  logic            out_vld, out_rdy, out_opcode;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_sideband;
  logic [IW-1:0]   out_src_id, out_tgt_id;
  logic [1:0]      out_src_idx;
`ifdef TOY_BUS_ACK_SCHED_STARVE_WDOG_EN
  logic [N-1:0]    starve_err;
`endif

  toy_bus_ack_sched #(.NUM_IN(N), .DATA_W(DW), .SB_W(SW), .ID_W(IW), .STARVE_TH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_opcode(in_opcode), .in_data(in_data),
    .in_sideband(in_sideband), .in_src_id(in_src_id), .in_tgt_id(in_tgt_id),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_opcode(out_opcode), .out_data(out_data),
    .out_sideband(out_sideband), .out_src_id(out_src_id), .out_tgt_id(out_tgt_id),
    .out_src_idx(out_src_idx)
`ifdef TOY_BUS_ACK_SCHED_STARVE_WDOG_EN
    , .starve_err(starve_err)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Per-requester current beat
  logic [DW-1:0] p_data [N];
  logic [SW-1:0] p_sb   [N];
  logic [IW-1:0] p_src  [N];
  logic [IW-1:0] p_tgt  [N];
  logic          p_op   [N];

  // Reference model: queue front = least recently granted
  int            order[$];
  bit            m_vld;
  logic [DW-1:0] m_data;
  logic [SW-1:0] m_sb;
  logic [IW-1:0] m_src, m_tgt;
  logic          m_op;
  int            m_idx;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic new_beat(input int i);
    for (int k = 0; k < DW / 32; k++) p_data[i][k*32 +: 32] = $urandom;
    p_sb[i]  = $urandom;
    p_src[i] = IW'($urandom);
    p_tgt[i] = IW'($urandom);
    p_op[i]  = 1'($urandom);
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      in_data[i*DW +: DW]     = p_data[i];
      in_sideband[i*SW +: SW] = p_sb[i];
      in_src_id[i*IW +: IW]   = p_src[i];
      in_tgt_id[i*IW +: IW]   = p_tgt[i];
      in_opcode[i]            = p_op[i];
    end
  endtask

  task automatic model_reset();
    order.delete();
    for (int i = 0; i < N; i++) order.push_back(i);
    m_vld = 1'b0;
  endtask

  function automatic int pick(input logic [N-1:0] v);
    foreach (order[k]) if (v[order[k]]) return order[k];
    return -1;
  endfunction

  // Entered at posedge+1; drives, checks at negedge, advances model, returns at next posedge+1.
  task automatic step(input logic [N-1:0] v, input logic r, output logic [N-1:0] rdy_seen);
    int w;
    bit ld, acc;
    logic [N-1:0] exp_rdy;
    pack();
    in_vld  = v;
    out_rdy = r;
    #4;
    w  = pick(v);
    ld = !m_vld || r;
    exp_rdy = (w >= 0 && ld) ? N'(1) << w : '0;
    rdy_seen = in_rdy;
    chk("in_rdy", {{(DW-N){1'b0}}, in_rdy}, {{(DW-N){1'b0}}, exp_rdy});
    chk("out_vld", {{(DW-1){1'b0}}, out_vld}, {{(DW-1){1'b0}}, m_vld});
    if (m_vld) begin
      chk("out_data", out_data, m_data);
      chk("out_sideband", {{(DW-SW){1'b0}}, out_sideband}, {{(DW-SW){1'b0}}, m_sb});
      chk("out_ids", {{(DW-2*IW-1){1'b0}}, out_op_ids()}, {{(DW-2*IW-1){1'b0}}, m_op, m_src, m_tgt});
      chk("out_src_idx", {{(DW-2){1'b0}}, out_src_idx}, DW'(m_idx));
    end
    acc = ld && (w >= 0);
    if (ld) begin
      m_vld = acc;
      if (acc) begin
        m_data = p_data[w]; m_sb = p_sb[w]; m_src = p_src[w]; m_tgt = p_tgt[w];
        m_op = p_op[w]; m_idx = w;
        foreach (order[k]) if (order[k] == w) begin order.delete(k); break; end
        order.push_back(w);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (!v[i] || (acc && i == w)) new_beat(i);
  endtask

  function automatic logic [2*IW:0] out_op_ids();
    return {out_opcode, out_src_id, out_tgt_id};
  endfunction

  task automatic do_reset();
    rst_n  = 1'b0;
    in_vld = '0;
    #2;
    chk("async_rst_out_vld", {{(DW-1){1'b0}}, out_vld}, '0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [N-1:0]  rs;
  logic [DW-1:0] saved;

  initial begin
    rst_n = 1'b0; in_vld = '0; out_rdy = 1'b0;
    for (int i = 0; i < N; i++) new_beat(i);
    pack();
    model_reset();
    #12;
    chk("rst_out_vld", {{(DW-1){1'b0}}, out_vld}, '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_src_idx", {{(DW-2){1'b0}}, out_src_idx}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // All valid, no backpressure: strict rotation from reset order
    for (int k = 0; k < 8; k++) begin
      step(4'b1111, 1'b1, rs);
      chk("rot_idx", {{(DW-2){1'b0}}, out_src_idx}, DW'(k % 4));
    end
    // Backpressure: output frozen at last beat, then oldest (0) wins
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 1'b0, rs);
      chk("bp_rdy", {{(DW-N){1'b0}}, rs}, '0);
      chk("bp_hold_idx", {{(DW-2){1'b0}}, out_src_idx}, DW'(3));
    end
    step(4'b1111, 1'b1, rs);
    chk("bp_release_idx", {{(DW-2){1'b0}}, out_src_idx}, DW'(0));
    // Age ordering: grant 3, then 1 and 3 compete -> 1
    step(4'b1000, 1'b1, rs);
    step(4'b1010, 1'b1, rs);
    chk("age_idx", {{(DW-2){1'b0}}, out_src_idx}, DW'(1));

    // Single requester after reset
    do_reset();
    saved = p_data[2];
    step(4'b0100, 1'b1, rs);
    chk("single_rdy", {{(DW-N){1'b0}}, rs}, DW'(4'b0100));
    chk("single_vld", {{(DW-1){1'b0}}, out_vld}, DW'(1));
    chk("single_idx", {{(DW-2){1'b0}}, out_src_idx}, DW'(2));
    chk("single_data", out_data, saved);
    // Withdraw: 0 drops under backpressure, 1 wins on release
    step(4'b0011, 1'b0, rs);
    step(4'b0011, 1'b0, rs);
    step(4'b0010, 1'b0, rs);
    step(4'b0010, 1'b1, rs);
    chk("withdraw_idx", {{(DW-2){1'b0}}, out_src_idx}, DW'(1));

    // Randomized traffic with one mid-run reset
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      step(N'($urandom), ($urandom_range(0, 9) < 7), rs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
